memory_request_unit: RTL and testbench
======================================

Name: memory_request_unit

Overview:
- Consumer side of the control unit's memory-control outputs. Turns decoded dREN/dWEN/halt into sequenced instruction and data memory requests to the cache.
- Performs the ihit/dhit handshakes and generates the PC advance enable.
- Sits between control_unit/datapath and the caches. Buffers the data address and store word for the duration of a data access.

Parameters:
- TIMEOUT_CYCLES, 1024, cycles without a hit before sticky timeout is raised; 0 disables the watchdog.
- WORD_W, 32, data/address width (word_t).

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  synchronous active-low reset.
- ihit  in  1  instruction cache hit; instruction valid this cycle.
- dhit  in  1  data cache hit; access complete this cycle.
- dREN_in  in  1  decoded load for the instruction presented during ihit.
- dWEN_in  in  1  decoded store for the instruction presented during ihit.
- halt_in  in  1  decoded HALT for the instruction presented during ihit.
- daddr_in  in  WORD_W  ALU-computed data address, valid with ihit.
- dstore_in  in  WORD_W  store data, valid with ihit.
- imemREN  out  1  instruction read request.
- dmemREN  out  1  data read request.
- dmemWEN  out  1  data write request.
- dmemaddr  out  WORD_W  latched data address.
- dmemstore  out  WORD_W  latched store data.
- pc_en  out  1  advance PC / retire instruction this cycle.
- halted  out  1  sticky halt indication.
- timeout  out  1  sticky watchdog indication.
- protocol_err  out  1  one-cycle pulse: dREN_in and dWEN_in both high on ihit.

Behaviour:
- Synchronous reset (nRST low at a rising edge) sets:
  - state FETCH, imemREN=1, dmemREN=0, dmemWEN=0.
  - dmemaddr=0, dmemstore=0.
  - halted=0, timeout=0, protocol_err=0.
  - watchdog counter=0, latched ren/wen=0.
- States are FETCH, MEM, HALT. Request outputs are Moore, decoded from state and the latched flags. pc_en is Mealy.
- FETCH:
  - Outputs: imemREN=1, dmemREN=0, dmemWEN=0.
  - ihit with halt_in=1: go to HALT; pc_en=0. halt takes priority over dREN_in/dWEN_in.
  - ihit with dREN_in|dWEN_in: latch daddr_in→dmemaddr and dstore_in→dmemstore, latch ren/wen, go to MEM; pc_en=0.
  - ihit with none of the above: pc_en=1 in the same cycle; stay in FETCH.
  - dhit in FETCH is ignored.
- MEM:
  - Outputs: imemREN=0; dmemREN=latched ren & ~latched wen; dmemWEN=latched wen.
  - Write has priority when both are latched.
  - dhit: pc_en=1 in the same cycle, clear the latched flags, return to FETCH. Next cycle imemREN=1.
  - ihit in MEM is ignored.
  - dmemaddr/dmemstore hold their values until the next MEM entry.
- protocol_err: pulses high the cycle after an ihit in FETCH with dREN_in=dWEN_in=1 (registered); the access proceeds as a write.
- HALT:
  - All requests 0, pc_en=0, halted=1 from the cycle after entry.
  - Exit only via reset.
- Latency:
  - Non-memory instruction: retires on its ihit cycle.
  - Load/store: retires on dhit. Minimum 1 cycle in MEM (dhit on the first MEM cycle).
- Watchdog (TIMEOUT_CYCLES>0):
  - Counter increments each cycle in FETCH without ihit or in MEM without dhit.
  - Counter clears on any accepted hit and on state change.
  - When counter reaches TIMEOUT_CYCLES-1 and the wait continues, timeout is set (sticky until reset).
  - Counter saturates; state is not altered.
  - Counter width is $clog2(TIMEOUT_CYCLES)+1.
- Reset mid-MEM: all requests drop on the following cycle; a late dhit after reset is ignored (state FETCH).

Optional Feature:
- MEMORY_REQUEST_PERF_EN defined: adds outputs instr_count (32) and stall_count (32), both reset to 0.
  - instr_count increments on every pc_en=1 cycle.
  - stall_count increments every cycle in FETCH or MEM with pc_en=0.
  - Both wrap modulo 2^32 and freeze in HALT.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then ihit=1 with no dREN/dWEN/halt for 3 cycles → pc_en=1 each cycle, imemREN=1, dmemREN=dmemWEN=0.
- ihit with dREN_in=1, daddr_in=0x0000_0040; dhit after 2 cycles → MEM for 3 cycles with dmemREN=1, dmemaddr=0x40, imemREN=0; pc_en=1 only on the dhit cycle; then FETCH.
- ihit with dWEN_in=1, dstore_in=0xDEAD_BEEF, dhit same first MEM cycle → dmemWEN=1 for 1 cycle, dmemstore=0xDEADBEEF, then imemREN=1.
- ihit with dREN_in=dWEN_in=1 → protocol_err one-cycle pulse, dmemWEN=1, dmemREN=0.
- ihit with halt_in=1 and dREN_in=1 → HALT; halted=1 next cycle, all requests 0; later ihit/dhit have no effect until nRST=0 restores FETCH.
- TIMEOUT_CYCLES=8, hold ihit=0 in FETCH → timeout=1 after 8 waiting cycles and stays 1; imemREN remains 1. Assert nRST=0 during a MEM wait → next cycle state FETCH, dmemREN=0, timeout=0.

Source files
------------

// File: rtl/memory_request_if.sv
// Handshake/bus bundle between the memory request unit and the caches/decoder.
// MEMORY_REQUEST_PERF_EN adds the instr_count/stall_count performance outputs.
interface memory_request_if #(
  parameter int unsigned WORD_W = 32
);
  logic              ihit;
  logic              dhit;
  logic              dREN_in;
  logic              dWEN_in;
  logic              halt_in;
  logic [WORD_W-1:0] daddr_in;
  logic [WORD_W-1:0] dstore_in;
  logic              imemREN;
  logic              dmemREN;
  logic              dmemWEN;
  logic [WORD_W-1:0] dmemaddr;
  logic [WORD_W-1:0] dmemstore;
  logic              pc_en;
  logic              halted;
  logic              timeout;
  logic              protocol_err;
`ifdef MEMORY_REQUEST_PERF_EN
  logic [31:0]       instr_count;
  logic [31:0]       stall_count;

  modport master (
    input  ihit, dhit, dREN_in, dWEN_in, halt_in, daddr_in, dstore_in,
    output imemREN, dmemREN, dmemWEN, dmemaddr, dmemstore, pc_en, halted, timeout,
           protocol_err, instr_count, stall_count
  );

  modport slave (
    output ihit, dhit, dREN_in, dWEN_in, halt_in, daddr_in, dstore_in,
    input  imemREN, dmemREN, dmemWEN, dmemaddr, dmemstore, pc_en, halted, timeout,
           protocol_err, instr_count, stall_count
  );
`else
  modport master (
    input  ihit, dhit, dREN_in, dWEN_in, halt_in, daddr_in, dstore_in,
    output imemREN, dmemREN, dmemWEN, dmemaddr, dmemstore, pc_en, halted, timeout,
           protocol_err
  );

  modport slave (
    output ihit, dhit, dREN_in, dWEN_in, halt_in, daddr_in, dstore_in,
    input  imemREN, dmemREN, dmemWEN, dmemaddr, dmemstore, pc_en, halted, timeout,
           protocol_err
  );
`endif
endinterface

// File: rtl/memory_request_unit.sv
// Sequences instruction/data cache requests from decoded load/store/halt, with watchdog.
// Optional MEMORY_REQUEST_PERF_EN adds retired-instruction and stall counters.
module memory_request_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned WORD_W         = 32
) (
  input logic              CLK,
  input logic              nRST,
  memory_request_if.master bus
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int unsigned TMaxInt = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CntW-1:0] TMax = CntW'(TMaxInt);

  typedef enum logic [1:0] {StFetch, StMem, StHalt} state_e;

  state_e            state_q, state_d;
  logic              ren_q, ren_d;
  logic              wen_q, wen_d;
  logic [WORD_W-1:0] daddr_q, daddr_d;
  logic [WORD_W-1:0] dstore_q, dstore_d;
  logic              imem_ren_q, imem_ren_d;
  logic              dmem_ren_q, dmem_ren_d;
  logic              dmem_wen_q, dmem_wen_d;
  logic              halted_q, halted_d;
  logic              timeout_q, timeout_d;
  logic              perr_q, perr_d;
  logic [CntW-1:0]   wd_cnt_q, wd_cnt_d;
  logic              pc_en;
  logic              waiting;

  always_comb begin
    state_d  = state_q;
    ren_d    = ren_q;
    wen_d    = wen_q;
    daddr_d  = daddr_q;
    dstore_d = dstore_q;
    pc_en    = 1'b0;
    waiting  = 1'b0;

    unique case (state_q)
      StFetch: begin
        if (bus.ihit) begin
          // halt wins over any memory access decoded alongside it
          if (bus.halt_in) begin
            state_d = StHalt;
          end else if (bus.dREN_in || bus.dWEN_in) begin
            state_d  = StMem;
            ren_d    = bus.dREN_in;
            wen_d    = bus.dWEN_in;
            daddr_d  = bus.daddr_in;
            dstore_d = bus.dstore_in;
          end else begin
            pc_en = 1'b1;
          end
        end else begin
          waiting = 1'b1;
        end
      end
      StMem: begin
        if (bus.dhit) begin
          pc_en   = 1'b1;
          ren_d   = 1'b0;
          wen_d   = 1'b0;
          state_d = StFetch;
        end else begin
          waiting = 1'b1;
        end
      end
      StHalt: begin
      end
      default: state_d = StFetch;
    endcase

    perr_d   = (state_q == StFetch) && bus.ihit && bus.dREN_in && bus.dWEN_in;
    halted_d = halted_q || (state_d == StHalt);

    // Request outputs are registered copies of the next-state decode
    imem_ren_d = (state_d == StFetch);
    dmem_ren_d = (state_d == StMem) && ren_d && !wen_d;
    dmem_wen_d = (state_d == StMem) && wen_d;

    timeout_d = timeout_q;
    wd_cnt_d  = '0;
    if (TIMEOUT_CYCLES != 0 && waiting) begin
      if (wd_cnt_q == TMax) begin
        wd_cnt_d  = wd_cnt_q;
        timeout_d = 1'b1;
      end else begin
        wd_cnt_d = wd_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q    <= StFetch;
      ren_q      <= 1'b0;
      wen_q      <= 1'b0;
      daddr_q    <= '0;
      dstore_q   <= '0;
      imem_ren_q <= 1'b1;
      dmem_ren_q <= 1'b0;
      dmem_wen_q <= 1'b0;
      halted_q   <= 1'b0;
      timeout_q  <= 1'b0;
      perr_q     <= 1'b0;
      wd_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      ren_q      <= ren_d;
      wen_q      <= wen_d;
      daddr_q    <= daddr_d;
      dstore_q   <= dstore_d;
      imem_ren_q <= imem_ren_d;
      dmem_ren_q <= dmem_ren_d;
      dmem_wen_q <= dmem_wen_d;
      halted_q   <= halted_d;
      timeout_q  <= timeout_d;
      perr_q     <= perr_d;
      wd_cnt_q   <= wd_cnt_d;
    end
  end

`ifdef MEMORY_REQUEST_PERF_EN
  logic [31:0] instr_q, stall_q;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      instr_q <= '0;
      stall_q <= '0;
    end else begin
      if (pc_en) begin
        instr_q <= instr_q + 32'd1;
      end
      if ((state_q == StFetch || state_q == StMem) && !pc_en) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  assign bus.instr_count = instr_q;
  assign bus.stall_count = stall_q;
`endif

  assign bus.imemREN      = imem_ren_q;
  assign bus.dmemREN      = dmem_ren_q;
  assign bus.dmemWEN      = dmem_wen_q;
  assign bus.dmemaddr     = daddr_q;
  assign bus.dmemstore    = dstore_q;
  assign bus.pc_en        = pc_en;
  assign bus.halted       = halted_q;
  assign bus.timeout      = timeout_q;
  assign bus.protocol_err = perr_q;

endmodule

// File: tb/tb_memory_request_unit.sv
// Directed bench for memory_request_unit: fetch, load, store, conflict, halt, watchdog, reset.
module tb_memory_request_unit;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  memory_request_if #(.WORD_W(32)) bus ();

  memory_request_unit #(
    .TIMEOUT_CYCLES(8),
    .WORD_W        (32)
  ) dut (
    .CLK (clk),
    .nRST(nrst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ihit      = 1'b0;
    bus.dhit      = 1'b0;
    bus.dREN_in   = 1'b0;
    bus.dWEN_in   = 1'b0;
    bus.halt_in   = 1'b0;
    bus.daddr_in  = 32'h1234_5678;
    bus.dstore_in = 32'h8765_4321;
  endtask

  initial begin
    idle_inputs();
    nrst = 1'b0;
    tick();
    nrst = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_imemREN", 32'(bus.imemREN), 32'd1);
    chk("rst_dmemREN", 32'(bus.dmemREN), 32'd0);
    chk("rst_dmemWEN", 32'(bus.dmemWEN), 32'd0);
    chk("rst_dmemaddr", bus.dmemaddr, 32'h0);
    chk("rst_dmemstore", bus.dmemstore, 32'h0);
    chk("rst_halted", 32'(bus.halted), 32'd0);
    chk("rst_timeout", 32'(bus.timeout), 32'd0);
    chk("rst_perr", 32'(bus.protocol_err), 32'd0);
    chk("rst_pc_en_noihit", 32'(bus.pc_en), 32'd0);

    // Plain instructions retire on their ihit cycle
    tick();
    for (int i = 0; i < 3; i++) begin
      bus.ihit = 1'b1;
      @(negedge clk);
      chk("alu_pc_en", 32'(bus.pc_en), 32'd1);
      chk("alu_imemREN", 32'(bus.imemREN), 32'd1);
      chk("alu_dreq", {30'd0, bus.dmemREN, bus.dmemWEN}, 32'd0);
      tick();
    end

    // Load, dhit on the third MEM cycle; ihit+halt during MEM is ignored
    bus.dREN_in  = 1'b1;
    bus.daddr_in = 32'h0000_0040;
    @(negedge clk);
    chk("ld_issue_pc_en", 32'(bus.pc_en), 32'd0);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("ld_m1_dmemREN", 32'(bus.dmemREN), 32'd1);
    chk("ld_m1_dmemWEN", 32'(bus.dmemWEN), 32'd0);
    chk("ld_m1_imemREN", 32'(bus.imemREN), 32'd0);
    chk("ld_m1_addr", bus.dmemaddr, 32'h0000_0040);
    chk("ld_m1_pc_en", 32'(bus.pc_en), 32'd0);
    tick();
    bus.ihit    = 1'b1;
    bus.halt_in = 1'b1;
    @(negedge clk);
    chk("ld_m2_dmemREN", 32'(bus.dmemREN), 32'd1);
    chk("ld_m2_pc_en", 32'(bus.pc_en), 32'd0);
    tick();
    idle_inputs();
    bus.dhit = 1'b1;
    @(negedge clk);
    chk("ld_m3_dmemREN", 32'(bus.dmemREN), 32'd1);
    chk("ld_m3_pc_en", 32'(bus.pc_en), 32'd1);
    tick();
    bus.dhit = 1'b0;
    @(negedge clk);
    chk("ld_ret_imemREN", 32'(bus.imemREN), 32'd1);
    chk("ld_ret_dmemREN", 32'(bus.dmemREN), 32'd0);
    chk("ld_ret_halted", 32'(bus.halted), 32'd0);
    chk("ld_ret_addr_hold", bus.dmemaddr, 32'h0000_0040);

    // Store with dhit on the first MEM cycle
    bus.ihit      = 1'b1;
    bus.dWEN_in   = 1'b1;
    bus.daddr_in  = 32'h0000_0080;
    bus.dstore_in = 32'hDEAD_BEEF;
    tick();
    idle_inputs();
    bus.dhit = 1'b1;
    @(negedge clk);
    chk("st_dmemWEN", 32'(bus.dmemWEN), 32'd1);
    chk("st_dmemREN", 32'(bus.dmemREN), 32'd0);
    chk("st_imemREN", 32'(bus.imemREN), 32'd0);
    chk("st_store", bus.dmemstore, 32'hDEAD_BEEF);
    chk("st_addr", bus.dmemaddr, 32'h0000_0080);
    chk("st_pc_en", 32'(bus.pc_en), 32'd1);
    tick();
    // dhit lingering into FETCH must not retire anything
    @(negedge clk);
    chk("st_ret_imemREN", 32'(bus.imemREN), 32'd1);
    chk("st_ret_dmemWEN", 32'(bus.dmemWEN), 32'd0);
    chk("fetch_dhit_pc_en", 32'(bus.pc_en), 32'd0);
    chk("st_ret_store_hold", bus.dmemstore, 32'hDEAD_BEEF);
    tick();

    // Load and store both decoded: error pulse, proceeds as write
    idle_inputs();
    bus.ihit      = 1'b1;
    bus.dREN_in   = 1'b1;
    bus.dWEN_in   = 1'b1;
    bus.daddr_in  = 32'h0000_0100;
    bus.dstore_in = 32'h0000_0055;
    @(negedge clk);
    chk("pe_issue_perr", 32'(bus.protocol_err), 32'd0);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("pe_perr_pulse", 32'(bus.protocol_err), 32'd1);
    chk("pe_dmemWEN", 32'(bus.dmemWEN), 32'd1);
    chk("pe_dmemREN", 32'(bus.dmemREN), 32'd0);
    tick();
    bus.dhit = 1'b1;
    @(negedge clk);
    chk("pe_perr_clear", 32'(bus.protocol_err), 32'd0);
    chk("pe_pc_en", 32'(bus.pc_en), 32'd1);
    tick();
    idle_inputs();

    // Halt beats a simultaneous load
    bus.ihit    = 1'b1;
    bus.halt_in = 1'b1;
    bus.dREN_in = 1'b1;
    @(negedge clk);
    chk("hlt_issue_pc_en", 32'(bus.pc_en), 32'd0);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("hlt_halted", 32'(bus.halted), 32'd1);
    chk("hlt_reqs", {29'd0, bus.imemREN, bus.dmemREN, bus.dmemWEN}, 32'd0);
    tick();
    for (int i = 0; i < 2; i++) begin
      bus.ihit = 1'b1;
      bus.dhit = 1'b1;
      @(negedge clk);
      chk("hlt_stuck_pc_en", 32'(bus.pc_en), 32'd0);
      chk("hlt_stuck_halted", 32'(bus.halted), 32'd1);
      chk("hlt_stuck_imemREN", 32'(bus.imemREN), 32'd0);
      tick();
    end
    idle_inputs();
    nrst = 1'b0;
    tick();
    nrst = 1'b1;

    // Watchdog: first waiting cycle is the one right after reset
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("wd_before", 32'(bus.timeout), 32'd0);
      if (i == 1) begin
        chk("hlt_reset_imemREN", 32'(bus.imemREN), 32'd1);
        chk("hlt_reset_halted", 32'(bus.halted), 32'd0);
      end
      tick();
    end
    @(negedge clk);
    chk("wd_set", 32'(bus.timeout), 32'd1);
    chk("wd_imemREN", 32'(bus.imemREN), 32'd1);
    tick();
    bus.ihit = 1'b1;
    @(negedge clk);
    chk("wd_sticky", 32'(bus.timeout), 32'd1);
    chk("wd_pc_en", 32'(bus.pc_en), 32'd1);

    // Reset in the middle of a load wait; late dhit ignored
    bus.dREN_in  = 1'b1;
    bus.daddr_in = 32'h0000_0200;
    tick();
    idle_inputs();
    @(negedge clk);
    chk("rm_dmemREN", 32'(bus.dmemREN), 32'd1);
    chk("rm_timeout_held", 32'(bus.timeout), 32'd1);
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    bus.dhit = 1'b1;
    @(negedge clk);
    chk("rm_imemREN", 32'(bus.imemREN), 32'd1);
    chk("rm_dmemREN_drop", 32'(bus.dmemREN), 32'd0);
    chk("rm_timeout_clr", 32'(bus.timeout), 32'd0);
    chk("rm_late_dhit_pc_en", 32'(bus.pc_en), 32'd0);
    chk("rm_addr_clr", bus.dmemaddr, 32'h0);
    tick();
    bus.dhit = 1'b0;
    @(negedge clk);
    chk("rm_still_fetch", 32'(bus.imemREN), 32'd1);
    chk("rm_no_dreq", {30'd0, bus.dmemREN, bus.dmemWEN}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
